// File: rtl/uart_echo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_echo_pkg
// Description : Shared definitions for the UART echo core. Holds the mode
//               encodings, FSM state encoding, ASCII constants and the
//               case-swap helper.
//               Optional feature macro: UART_ECHO_CRLF_EN (CR -> CR LF).
// Revision    : 1.0  initial release
// ============================================================================
package uart_echo_pkg;

    // Values of the 2-bit i_mode input
    localparam logic [1:0] MODE_RAW      = 2'b00;
    localparam logic [1:0] MODE_ECHO     = 2'b01;
    localparam logic [1:0] MODE_SWAPCASE = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // ST_LF is only reachable when UART_ECHO_CRLF_EN is defined
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_LF   = 2'd2
    } echo_state_t;

    // Letters A-Z / a-z differ only in bit 5; everything else passes through
    function automatic logic [7:0] swap_case(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A)))
            r[5] = ~b[5];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_echo_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_echo_fifo
// Description : Synchronous byte FIFO, depth 2**LGFLEN. The head entry is
//               read straight from the storage array, so a popped byte is
//               replaced by the next one in the same cycle.
// Ports       : i_clk, i_reset_n (async, active-low)
//               i_push / i_data  - write request and byte
//               i_pop            - remove head entry
//               o_head           - current head byte (valid when !o_empty)
//               o_full, o_empty  - status
//               o_fill           - occupancy, LGFLEN+1 bits
// Revision    : 1.0  initial release
// ============================================================================
module uart_echo_fifo #(
    parameter int LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_push,
    input  logic [7:0]        i_data,
    input  logic              i_pop,
    output logic [7:0]        o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic [LGFLEN:0]   o_fill
);

    localparam int c_depth = 2 ** LGFLEN;

    logic [7:0]      r_mem [c_depth];
    logic [LGFLEN:0] r_wr_ptr;
    logic [LGFLEN:0] r_rd_ptr;
    logic            w_push_ok;
    logic            w_pop_ok;

    // Pointers carry one extra wrap bit: equal -> empty, only MSB differs -> full
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[LGFLEN] != r_rd_ptr[LGFLEN]) &&
                     (r_wr_ptr[LGFLEN-1:0] == r_rd_ptr[LGFLEN-1:0]);
    assign o_fill  = r_wr_ptr - r_rd_ptr;

    assign w_pop_ok  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot the push is about to use
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; pointers define what is valid
    always_ff @(posedge i_clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr[LGFLEN-1:0]] <= i_data;
    end

    assign o_head = r_mem[r_rd_ptr[LGFLEN-1:0]];

endmodule
`default_nettype wire

// File: rtl/uart_echo_buf.sv
`default_nettype none
// ============================================================================
// Module      : uart_echo_buf
// Description : UART echo core between rxuart and txuart. Received bytes are
//               queued in a FIFO and handed to the transmitter by a
//               write/busy handshake FSM. RAW mode instead echoes the serial
//               line bit by bit through one register. Optional case swap,
//               HOLD pause, sticky overflow flag and saturating drop count.
//               Optional feature macro: UART_ECHO_CRLF_EN - after a CR is
//               accepted by txuart an LF is offered as well.
// Ports       : i_clk, i_reset_n (async, active-low)
//               i_mode     - 00 RAW, 01 ECHO, 10 SWAPCASE, 11 HOLD
//               i_clr      - clear overflow flag and drop counter
//               i_uart_rx  - serial in (RAW path)
//               i_rx_stb, i_rx_data  - byte strobe from rxuart
//               i_tx_busy, i_tx_ser  - txuart busy and serial out
//               o_tx_wr, o_tx_data   - write request to txuart
//               o_uart_tx  - serial line out
//               o_fill, o_overflow, o_drop_cnt - buffer status
// Revision    : 1.0  initial release
// ============================================================================
module uart_echo_buf #(
    parameter int LGFLEN = 4,
    parameter int CNTW   = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [1:0]        i_mode,
    input  logic              i_clr,
    input  logic              i_uart_rx,
    input  logic              i_rx_stb,
    input  logic [7:0]        i_rx_data,
    input  logic              i_tx_busy,
    input  logic              i_tx_ser,
    output logic              o_tx_wr,
    output logic [7:0]        o_tx_data,
    output logic              o_uart_tx,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_overflow,
    output logic [CNTW-1:0]   o_drop_cnt
);

    import uart_echo_pkg::*;

    localparam logic [CNTW-1:0] c_cnt_max = '1;

    echo_state_t      r_state;
    logic             r_tx_wr;
    logic [7:0]       r_tx_data;
    logic             r_raw_tx;
    logic             r_raw_sel;
    logic             r_overflow;
    logic [CNTW-1:0]  r_drop_cnt;

    logic             w_tx_mode;
    logic             w_push_req;
    logic             w_pop;
    logic             w_drop;
    logic [7:0]       w_head;
    logic             w_full;
    logic             w_empty;
    logic [LGFLEN:0]  w_fill;

    assign w_tx_mode  = (i_mode == MODE_ECHO) || (i_mode == MODE_SWAPCASE);
    assign w_push_req = i_rx_stb && (i_mode != MODE_RAW);
    // In SEND the head entry is the byte on offer, so accept == pop
    assign w_pop      = (r_state == ST_SEND) && !i_tx_busy;
    assign w_drop     = w_push_req && w_full && !w_pop;

    uart_echo_fifo #(
        .LGFLEN (LGFLEN)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (w_push_req),
        .i_data    (i_rx_data),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_fill    (w_fill)
    );

    // ------------------------------------------------------------------
    // Transmit handshake FSM. Once o_tx_wr is raised it stays up until
    // txuart takes the byte, whatever happens to i_mode meanwhile.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_tx_wr   <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty && w_tx_mode) begin
                        r_tx_data <= (i_mode == MODE_SWAPCASE) ? swap_case(w_head) : w_head;
                        r_tx_wr   <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!i_tx_busy) begin
`ifdef UART_ECHO_CRLF_EN
                        // Checked on the swapped byte; the LF is not a FIFO entry
                        if (r_tx_data == ASCII_CR) begin
                            r_tx_data <= ASCII_LF;
                            r_state   <= ST_LF;
                        end else
`endif
                        begin
                            r_tx_wr <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
`ifdef UART_ECHO_CRLF_EN
                ST_LF: begin
                    if (!i_tx_busy) begin
                        r_tx_wr <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    r_tx_wr <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Overflow flag and saturating drop counter; clear wins over a drop
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (i_clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != c_cnt_max)
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Serial output path. The select is registered alongside the raw bit
    // and resets to the raw side, so reset forces an idle mark on the line
    // regardless of what txuart is driving.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_raw_tx  <= 1'b1;
            r_raw_sel <= 1'b1;
        end else begin
            r_raw_tx  <= i_uart_rx;
            r_raw_sel <= (i_mode == MODE_RAW);
        end
    end

    assign o_uart_tx  = r_raw_sel ? r_raw_tx : i_tx_ser;
    assign o_tx_wr    = r_tx_wr;
    assign o_tx_data  = r_tx_data;
    assign o_fill     = w_fill;
    assign o_overflow = r_overflow;
    assign o_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_echo_buf
// Description : Directed self-checking bench for uart_echo_buf (LGFLEN=2).
//               Expectations follow UART_ECHO_CRLF_EN when it is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_echo_buf;

    localparam int LGFLEN = 2;
    localparam int CNTW   = 8;

    logic              clk;
    logic              rst_n;
    logic [1:0]        mode;
    logic              clr;
    logic              uart_rx;
    logic              rx_stb;
    logic [7:0]        rx_data;
    logic              tx_busy;
    logic              tx_ser;
    logic              o_tx_wr;
    logic [7:0]        o_tx_data;
    logic              o_uart_tx;
    logic [LGFLEN:0]   o_fill;
    logic              o_overflow;
    logic [CNTW-1:0]   o_drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] got [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_echo_buf #(
        .LGFLEN (LGFLEN),
        .CNTW   (CNTW)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_mode     (mode),
        .i_clr      (clr),
        .i_uart_rx  (uart_rx),
        .i_rx_stb   (rx_stb),
        .i_rx_data  (rx_data),
        .i_tx_busy  (tx_busy),
        .i_tx_ser   (tx_ser),
        .o_tx_wr    (o_tx_wr),
        .o_tx_data  (o_tx_data),
        .o_uart_tx  (o_uart_tx),
        .o_fill     (o_fill),
        .o_overflow (o_overflow),
        .o_drop_cnt (o_drop_cnt)
    );

    // txuart stand-in: a byte is taken on the edge following a negedge
    // where write is requested and busy is low
    always @(negedge clk) begin
        if (rst_n && o_tx_wr && !tx_busy)
            got.push_back(o_tx_data);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got.size())
            return {24'h0, got[i]};
        return 32'hDEAD;
    endfunction

    task automatic strobe(input logic [7:0] d);
        rx_stb  = 1'b1;
        rx_data = d;
        step();
        rx_stb  = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int k;
        k = 0;
        while ((got.size() < n) && (k < 200)) begin
            step();
            k++;
        end
        chk("drain_count", got.size(), n);
    endtask

    initial begin
        logic [3:0] raw_pat;
        logic       prev;
        logic [7:0] sw_in  [6];
        logic [7:0] sw_exp [6];
        logic [7:0] cr_exp [$];

        raw_pat = 4'b1001;
        sw_in   = '{8'h41, 8'h7A, 8'h5B, 8'h40, 8'h60, 8'h7B};
        sw_exp  = '{8'h61, 8'h5A, 8'h5B, 8'h40, 8'h60, 8'h7B};

        rst_n = 1'b0; mode = 2'b00; clr = 1'b0; uart_rx = 1'b1;
        rx_stb = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; tx_ser = 1'b1;
        step(3);

        // ---------------- reset state ----------------
        chk("rst_tx_wr",   o_tx_wr,    1'b0);
        chk("rst_tx_data", o_tx_data,  8'h00);
        chk("rst_uart_tx", o_uart_tx,  1'b1);
        chk("rst_fill",    o_fill,     3'd0);
        chk("rst_ovf",     o_overflow, 1'b0);
        chk("rst_drop",    o_drop_cnt, 8'd0);
        rst_n = 1'b1;
        step();

        // ---------------- RAW: 1-cycle registered echo ----------------
        prev = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            uart_rx = raw_pat[i];
            #1;
            chk("raw_before_edge", o_uart_tx, prev);
            step();
            chk("raw_after_edge", o_uart_tx, raw_pat[i]);
            prev = raw_pat[i];
        end
        uart_rx = 1'b1;
        strobe(8'h11);
        strobe(8'h22);
        step();
        chk("raw_fill", o_fill, 3'd0);
        chk("raw_tx_wr", o_tx_wr, 1'b0);

        // ---------------- ECHO ----------------
        mode = 2'b01;
        step();
        tx_ser = 1'b0;
        #1;
        chk("ser_pass_0", o_uart_tx, 1'b0);
        tx_ser = 1'b1;
        #1;
        chk("ser_pass_1", o_uart_tx, 1'b1);
        got.delete();
        strobe(8'h41);
        chk("echo_nobypass_fill", o_fill, 3'd1);
        chk("echo_nobypass_wr",   o_tx_wr, 1'b0);
        strobe(8'h62);
        chk("echo_offer_wr",   o_tx_wr, 1'b1);
        chk("echo_offer_data", o_tx_data, 8'h41);
        wait_got(2);
        chk("echo_b0", got_at(0), 8'h41);
        chk("echo_b1", got_at(1), 8'h62);
        step(2);
        chk("echo_fill", o_fill, 3'd0);
        chk("echo_idle_wr", o_tx_wr, 1'b0);
        chk("echo_count", got.size(), 2);

        // ---------------- SWAPCASE ----------------
        mode = 2'b10;
        got.delete();
        for (int i = 0; i < 6; i++) begin
            strobe(sw_in[i]);
            step();
        end
        wait_got(6);
        for (int i = 0; i < 6; i++)
            chk("swap_byte", got_at(i), sw_exp[i]);
        chk("swap_ovf", o_overflow, 1'b0);
        step(4);

        // ---------------- HOLD, overflow, saturation, clear ----------------
        mode = 2'b11;
        got.delete();
        for (int i = 0; i < 6; i++)
            strobe(8'h31 + 8'(i));
        step(2);
        chk("hold_fill", o_fill, 3'd4);
        chk("hold_ovf",  o_overflow, 1'b1);
        chk("hold_drop", o_drop_cnt, 8'd2);
        chk("hold_wr",   o_tx_wr, 1'b0);
        repeat (260) strobe(8'hEE);
        chk("sat_drop", o_drop_cnt, 8'hFF);
        chk("sat_ovf",  o_overflow, 1'b1);
        chk("sat_fill", o_fill, 3'd4);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_drop", o_drop_cnt, 8'd0);
        chk("clr_ovf",  o_overflow, 1'b0);
        clr = 1'b1; rx_stb = 1'b1; rx_data = 8'hEE;
        step();
        clr = 1'b0; rx_stb = 1'b0;
        chk("clrprio_drop", o_drop_cnt, 8'd0);
        chk("clrprio_ovf",  o_overflow, 1'b0);
        chk("clrprio_fill", o_fill, 3'd4);
        strobe(8'hEE);
        chk("drop_after_clr", o_drop_cnt, 8'd1);
        chk("ovf_after_clr",  o_overflow, 1'b1);
        clr = 1'b1;
        step();
        clr = 1'b0;

        // ---------------- busy held: offer stable, single pop ----------------
        tx_busy = 1'b1;
        mode = 2'b01;
        got.delete();
        step(2);
        for (int i = 0; i < 20; i++) begin
            chk("busy_wr",   o_tx_wr, 1'b1);
            chk("busy_data", o_tx_data, 8'h31);
            chk("busy_fill", o_fill, 3'd4);
            step();
        end
        chk("busy_none_taken", got.size(), 0);
        // Release and push into the full FIFO in the same cycle
        tx_busy = 1'b0; rx_stb = 1'b1; rx_data = 8'h37;
        step();
        rx_stb = 1'b0;
        chk("fullpp_fill", o_fill, 3'd4);
        chk("fullpp_drop", o_drop_cnt, 8'd0);
        chk("fullpp_ovf",  o_overflow, 1'b0);
        chk("release_taken", got.size(), 1);
        wait_got(5);
        chk("drain_b0", got_at(0), 8'h31);
        chk("drain_b1", got_at(1), 8'h32);
        chk("drain_b2", got_at(2), 8'h33);
        chk("drain_b3", got_at(3), 8'h34);
        chk("drain_b4", got_at(4), 8'h37);
        step(3);
        chk("drain_fill", o_fill, 3'd0);

        // ---------------- mode change mid-SEND ----------------
        got.delete();
        tx_busy = 1'b1;
        strobe(8'h5A);
        step();
        chk("midsend_wr", o_tx_wr, 1'b1);
        mode = 2'b11;
        step(2);
        chk("midsend_hold_wr",   o_tx_wr, 1'b1);
        chk("midsend_hold_data", o_tx_data, 8'h5A);
        mode = 2'b00;
        step();
        chk("midsend_raw_wr",   o_tx_wr, 1'b1);
        chk("midsend_raw_data", o_tx_data, 8'h5A);
        mode = 2'b11;
        tx_busy = 1'b0;
        step();
        chk("midsend_taken", got_at(0), 8'h5A);
        step();
        chk("midsend_done_wr", o_tx_wr, 1'b0);
        chk("midsend_fill",    o_fill, 3'd0);

        // ---------------- HOLD / RAW retain contents ----------------
        strobe(8'h66);
        step(2);
        chk("retain_hold_fill", o_fill, 3'd1);
        chk("retain_hold_wr",   o_tx_wr, 1'b0);
        mode = 2'b00;
        strobe(8'h77);
        step(2);
        chk("retain_raw_fill", o_fill, 3'd1);
        chk("retain_raw_wr",   o_tx_wr, 1'b0);
        mode = 2'b01;
        wait_got(2);
        chk("retain_byte", got_at(1), 8'h66);
        step(2);
        chk("retain_fill_end", o_fill, 3'd0);

        // ---------------- CR handling ----------------
        got.delete();
`ifdef UART_ECHO_CRLF_EN
        cr_exp = '{8'h0D, 8'h0A, 8'h41};
`else
        cr_exp = '{8'h0D, 8'h41};
`endif
        strobe(8'h0D);
        step();
        strobe(8'h41);
        wait_got(cr_exp.size());
        for (int i = 0; i < cr_exp.size(); i++)
            chk("cr_byte", got_at(i), cr_exp[i]);
        step(3);
        chk("cr_fill", o_fill, 3'd0);
        chk("cr_wr",   o_tx_wr, 1'b0);
        chk("cr_count", got.size(), cr_exp.size());

        // ---------------- reset mid-SEND ----------------
        got.delete();
        tx_busy = 1'b1;
        strobe(8'h55);
        strobe(8'h56);
        step();
        chk("pre_rst_wr", o_tx_wr, 1'b1);
        tx_ser = 1'b0;
        #1;
        chk("pre_rst_line", o_uart_tx, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wr",   o_tx_wr,    1'b0);
        chk("async_rst_data", o_tx_data,  8'h00);
        chk("async_rst_line", o_uart_tx,  1'b1);
        chk("async_rst_fill", o_fill,     3'd0);
        chk("async_rst_ovf",  o_overflow, 1'b0);
        chk("async_rst_drop", o_drop_cnt, 8'd0);
        step(2);
        rst_n = 1'b1;
        tx_ser = 1'b1;
        tx_busy = 1'b0;
        step(10);
        chk("post_rst_nothing_sent", got.size(), 0);
        chk("post_rst_fill", o_fill, 3'd0);
        chk("post_rst_wr",   o_tx_wr, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
